// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table, blank pattern
// and a constant-width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp, g..a}; dp bit is 1 (off) in every entry.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Bits needed to hold 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/seg7_scanner_if.sv
// Display register bundle between the CPU-visible registers and the scanner,
// plus the scanned anode/segment lines and frame strobe.
interface seg7_scanner_if #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned BRIGHT_W = 4
) ();

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   digit_en;
    logic                blank_lz;
    logic [BRIGHT_W-1:0] brightness;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                frame_done;

    modport master (
        output data, dp, digit_en, blank_lz, brightness,
        input  an, seg, frame_done
    );

    modport slave (
        input  data, dp, digit_en, blank_lz, brightness,
        output an, seg, frame_done
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low g..a segment decode.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = HEX_SEG[nibble][6:0];
    end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment scanner: prescaler, slot counter, frame-coherent
// shadow registers, leading-zero/PWM qualification and registered outputs.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned SCAN_DIV  = 2500,
    parameter int unsigned BRIGHT_W  = 4,
    parameter int unsigned BLANK_CYC = 2
) (
    input logic           clk,
    input logic           rst_n,
    seg7_scanner_if.slave bus
);

    localparam int unsigned PW = clog2(SCAN_DIV);
    localparam int unsigned SW = clog2(DIGITS);
    localparam int unsigned OW = BRIGHT_W + clog2(SCAN_DIV) + 1;

    localparam logic [PW-1:0] PCNT_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CYC);
    localparam logic [SW-1:0] SEL_LAST   = SW'(DIGITS - 1);
    localparam logic [OW-1:0] DIV_EXT    = OW'(SCAN_DIV);

    if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
        $error("seg7_scanner: DIGITS must be within 2..16");
    end
    if (SCAN_DIV < (1 << BRIGHT_W)) begin : g_bad_div_bright
        $error("seg7_scanner: SCAN_DIV must be at least 2**BRIGHT_W");
    end
    if (SCAN_DIV <= BLANK_CYC) begin : g_bad_div_blank
        $error("seg7_scanner: SCAN_DIV must exceed BLANK_CYC");
    end

    logic [PW-1:0]       pcnt;
    logic [SW-1:0]       sel;

    logic [4*DIGITS-1:0] data_s;
    logic [DIGITS-1:0]   dp_s;
    logic [DIGITS-1:0]   en_s;
    logic                lz_s;
    logic [BRIGHT_W-1:0] bright_s;

    logic [DIGITS-1:0]   an_q;
    logic [7:0]          seg_q;
    logic                frame_done_q;

    logic                tick;
    logic                frame_end;
    logic [OW-1:0]       on_len;
    logic                blanked;
    logic                lit;
    logic [3:0]          nibble;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   an_next;
    logic [7:0]          seg_next;

    seg7_decode u_decode (
        .nibble (nibble),
        .segs   (dec_seg)
    );

    always_comb begin
        tick      = (pcnt == PCNT_LAST);
        frame_end = tick && (sel == SEL_LAST);
        on_len    = ((OW'(bright_s) + OW'(1)) * DIV_EXT) >> BRIGHT_W;
        nibble    = data_s[4*sel +: 4];
        // Shifting out the lower nibbles leaves exactly digits sel..DIGITS-1.
        blanked   = lz_s && (sel != '0) && ((data_s >> (4*sel)) == '0);
        lit       = (pcnt >= PCNT_BLANK) && (OW'(pcnt) < on_len) && en_s[sel] && !blanked;
        an_next   = '1;
        seg_next  = SEG_OFF;
        if (lit) begin
            an_next  = ~(DIGITS'(1) << sel);
            seg_next = {~dp_s[sel], dec_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt         <= '0;
            sel          <= '0;
            data_s       <= '0;
            dp_s         <= '0;
            en_s         <= '0;
            lz_s         <= 1'b0;
            bright_s     <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                sel <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
            end
            // Shadows change only between frames so a frame never shows torn data.
            if (frame_end) begin
                data_s   <= bus.data;
                dp_s     <= bus.dp;
                en_s     <= bus.digit_en;
                lz_s     <= bus.blank_lz;
                bright_s <= bus.brightness;
            end
            frame_done_q <= frame_end;
            an_q         <= an_next;
            seg_q        <= seg_next;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Randomised bench for seg7_scanner against a frame-level arithmetic model.
module tb_seg7_scanner;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 16;
    localparam int unsigned BRIGHT_W  = 2;
    localparam int unsigned BLANK_CYC = 1;
    localparam int          FRAME     = DIGITS * SCAN_DIV;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg7_scanner_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

    seg7_scanner #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BRIGHT_W  (BRIGHT_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: cyc counts clock edges since reset release.
    int         cyc;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_en;
    logic        sh_lz;
    logic [1:0]  sh_br;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_fd;

    // What the display shows for the cycle whose index since release is c.
    function automatic logic [11:0] model_out(input int c);
        int          p;
        int          s;
        int          on_len;
        bit          lz;
        bit          lit;
        logic [3:0]  nib;
        logic [7:0]  glyph;
        p      = c % SCAN_DIV;
        s      = (c / SCAN_DIV) % DIGITS;
        on_len = ((int'(sh_br) + 1) * SCAN_DIV) / (1 << BRIGHT_W);
        lz     = sh_lz && (s != 0) && ((sh_data >> (4 * s)) == 16'h0);
        lit    = (p >= BLANK_CYC) && (p < on_len) && sh_en[s] && !lz;
        nib    = 4'(sh_data >> (4 * s));
        glyph  = GLYPH[nib];
        if (lit) return {~(4'b0001 << s), ~sh_dp[s], glyph[6:0]};
        return {4'hF, 8'hFF};
    endfunction

    task automatic model_reset();
        cyc     = 0;
        sh_data = '0;
        sh_dp   = '0;
        sh_en   = '0;
        sh_lz   = 1'b0;
        sh_br   = '0;
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
        exp_fd  = 1'b0;
    endtask

    // Advance one clock; expectations land in exp_* and the bench sits 1 time unit past the edge.
    task automatic step();
        logic [11:0] m;
        @(posedge clk);
        m       = model_out(cyc);
        exp_an  = m[11:8];
        exp_seg = m[7:0];
        exp_fd  = (cyc % FRAME) == FRAME - 1;
        if (exp_fd) begin
            sh_data = bus.data;
            sh_dp   = bus.dp;
            sh_en   = bus.digit_en;
            sh_lz   = bus.blank_lz;
            sh_br   = bus.brightness;
        end
        cyc++;
        #1;
    endtask

    // Run through the next frame boundary so the current inputs become the shadow.
    task automatic align();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((cyc % FRAME) != 0 && n < 2 * FRAME);
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                              input logic lz, input logic [1:0] b);
        bus.data       = d;
        bus.dp         = p;
        bus.digit_en   = e;
        bus.blank_lz   = lz;
        bus.brightness = b;
    endtask

    task automatic test_reset();
        int lit [4];
        set_inputs(16'h12A0, 4'h0, 4'hF, 1'b0, 2'd3);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_state an=%h seg=%h fd=%b expected an=f seg=ff fd=0",
                     bus.an, bus.seg, bus.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++;
            if (bus.an !== 4'hF || {bus.seg, bus.frame_done} !== {exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL first_frame_dark cyc=%0d an=%h seg=%h fd=%b expected an=f seg=%h fd=%b",
                         cyc, bus.an, bus.seg, bus.frame_done, exp_seg, exp_fd);
            end
        end
        for (int d = 0; d < 4; d++) lit[d] = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL second_frame cyc=%0d an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                         cyc, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            for (int d = 0; d < 4; d++) begin
                if (bus.an == ~(4'b0001 << d)) begin
                    lit[d]++;
                    checks++;
                    if (bus.seg !== (d == 0 ? 8'hC0 : d == 1 ? 8'h88 : d == 2 ? 8'hA4 : 8'hF9)) begin
                        failures++;
                        $display("FAIL second_frame_glyph digit=%0d seg=%h", d, bus.seg);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != 15) begin
                failures++;
                $display("FAIL full_bright_lit digit=%0d lit=%0d expected 15", d, lit[d]);
            end
        end
    endtask

    task automatic test_min_bright();
        int lit [4];
        set_inputs(16'h4321, 4'h0, 4'hF, 1'b0, 2'd0);
        align();
        for (int d = 0; d < 4; d++) lit[d] = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL min_bright cyc=%0d an=%h seg=%h expected an=%h seg=%h",
                         cyc, bus.an, bus.seg, exp_an, exp_seg);
            end
            for (int d = 0; d < 4; d++) if (bus.an == ~(4'b0001 << d)) lit[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != 3) begin
                failures++;
                $display("FAIL min_bright_lit digit=%0d lit=%0d expected 3", d, lit[d]);
            end
        end
    endtask

    task automatic test_lz();
        int lit [4];
        for (int pass = 0; pass < 2; pass++) begin
            set_inputs(pass == 0 ? 16'h0050 : 16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);
            align();
            for (int d = 0; d < 4; d++) lit[d] = 0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                checks++;
                if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                    failures++;
                    $display("FAIL lz_model pass=%0d cyc=%0d an=%h seg=%h expected an=%h seg=%h",
                             pass, cyc, bus.an, bus.seg, exp_an, exp_seg);
                end
                for (int d = 0; d < 4; d++) if (bus.an == ~(4'b0001 << d)) lit[d]++;
                if (bus.an == 4'b1110 || (pass == 0 && bus.an == 4'b1101)) begin
                    checks++;
                    if (bus.seg !== (bus.an == 4'b1110 ? 8'hC0 : 8'h92)) begin
                        failures++;
                        $display("FAIL lz_glyph pass=%0d an=%h seg=%h", pass, bus.an, bus.seg);
                    end
                end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (lit[d] != ((d == 0 || (d == 1 && pass == 0)) ? 15 : 0)) begin
                    failures++;
                    $display("FAIL lz_lit pass=%0d digit=%0d lit=%0d", pass, d, lit[d]);
                end
            end
        end
    endtask

    task automatic test_frame_coherence();
        int last_fd;
        int pulses;
        last_fd = -1;
        pulses  = 0;
        set_inputs(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        align();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == SCAN_DIV + 4) bus.data = 16'h2222;
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL coherence_model cyc=%0d an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                         cyc, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (bus.an != 4'hF) begin
                checks++;
                if (bus.seg !== (i < FRAME ? 8'hF9 : 8'hA4)) begin
                    failures++;
                    $display("FAIL coherence_glyph i=%0d seg=%h expected %h",
                             i, bus.seg, (i < FRAME ? 8'hF9 : 8'hA4));
                end
            end
            if (bus.frame_done === 1'b1) begin
                pulses++;
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != FRAME) begin
                        failures++;
                        $display("FAIL frame_done_period got=%0d expected %0d", cyc - last_fd, FRAME);
                    end
                end
                last_fd = cyc;
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL frame_done_count got=%0d expected 2", pulses);
        end
    endtask

    task automatic test_dp_en();
        set_inputs(16'($urandom), 4'b0010, 4'b1011, 1'b0, 2'd3);
        align();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd} || bus.an[2] !== 1'b1)
            begin
                failures++;
                $display("FAIL dp_en cyc=%0d an=%h seg=%h expected an=%h seg=%h",
                         cyc, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (bus.an != 4'hF) begin
                checks++;
                if (bus.seg[7] !== (bus.an == 4'b1101 ? 1'b0 : 1'b1)) begin
                    failures++;
                    $display("FAIL dp_bit an=%h seg7=%b", bus.an, bus.seg[7]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(15) == 0) begin
                set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                           2'($urandom));
                if ($urandom_range(1) == 0) bus.data = 16'($urandom_range(255));
            end
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL random cyc=%0d an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                         cyc, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        int first_an;
        first_an = -1;
        set_inputs(16'h8421, 4'h0, 4'hF, 1'b0, 2'd3);
        align();
        for (int i = 0; i < SCAN_DIV + 5; i++) step();
        checks++;
        if (bus.an !== 4'b1101) begin
            failures++;
            $display("FAIL pre_reset_lit an=%h expected d", bus.an);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL async_reset an=%h seg=%h fd=%b expected an=f seg=ff fd=0",
                     bus.an, bus.seg, bus.frame_done);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                failures++;
                $display("FAIL post_reset cyc=%0d an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                         cyc, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (first_an < 0 && bus.an != 4'hF) first_an = int'(bus.an);
        end
        checks++;
        if (first_an != 14) begin
            failures++;
            $display("FAIL resume_digit0 first_an=%0d expected 14", first_an);
        end
    endtask

    initial begin
        set_inputs(16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        model_reset();
        test_reset();
        test_min_bright();
        test_lz();
        test_frame_coherence();
        test_dp_en();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Parametrised multiplexed seven-segment display scanner for the board top level. It time-multiplexes `DIGITS` hex digits onto shared active-low segment lines and per-digit active-low anodes. Scan timing is generated internally from the single system clock. Over a fixed-digit scanner it adds per-digit decimal points, a digit-enable mask, leading-zero suppression, PWM brightness, ghost-blanking dead time and frame-coherent shadow capture. It replaces the ad-hoc `AN`/`SEG` scan logic and is driven directly by CPU-visible display registers.

## Interface
- `DIGITS`, 8: number of digits/anodes (2..16).
- `SCAN_DIV`, 2500: clk cycles per digit slot; must be ≥ 2^`BRIGHT_W` and > `BLANK_CYC`.
- `BRIGHT_W`, 4: brightness control width.
- `BLANK_CYC`, 2: dark cycles at start of each slot (ghost suppression).

- `clk`  in  1  system clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data`  in  4*DIGITS  hex nibbles; nibble i = `data[4i+:4]` drives digit i (digit 0 rightmost).
- `dp`  in  DIGITS  decimal point per digit; 1 = lit.
- `digit_en`  in  DIGITS  per-digit enable; 0 = anode never driven.
- `blank_lz`  in  1  leading-zero suppression enable.
- `brightness`  in  BRIGHT_W  duty level; max = full on-window.
- `an`  out  DIGITS  anodes, active-low, registered.
- `seg`  out  8  segments, active-low, registered; `seg[6:0]` = g..a, `seg[7]` = dp.
- `frame_done`  out  1  one-clk pulse at each frame boundary (shadow load).

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `pcnt == SCAN_DIV-1`.
- Slot counter `sel` counts 0..DIGITS-1. It advances on `tick` and wraps DIGITS-1 → 0.
- Frame boundary: `tick` with `sel == DIGITS-1`. On that cycle the shadow registers load `data`, `dp`, `digit_en`, `blank_lz` and `brightness`, and `frame_done` is asserted on the next edge for one cycle.
- Inputs are sampled only at frame boundaries. Mid-frame changes have no visible effect.
- On-window length: `on_len = ((brightness_s + 1) * SCAN_DIV) >> BRIGHT_W`. Compute at width `BRIGHT_W + clog2(SCAN_DIV) + 1`; no overflow is permitted.
- Digit `sel` is lit when all of the following hold:
  - `pcnt >= BLANK_CYC`
  - `pcnt < on_len`
  - `digit_en_s[sel]`
  - the digit is not lz-blanked.
- If `on_len <= BLANK_CYC`, the digit stays dark for the whole slot.
- LZ-blanked: `blank_lz_s` is set, `sel != 0`, and every shadow nibble from `sel` to DIGITS-1 is zero. Digit 0 is never blanked.
- Lit digit: `an` = all ones except bit `sel` = 0; `seg` = {~dp_s[sel], hex decode}.
- Dark digit: `an` = all ones; `seg` = 8'hFF.
- Decode, active-low gfedcba, values given with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset (`rst_n` low, async, no clock needed) clears the following immediately:
  - outputs: `an` = all ones, `seg` = 8'hFF, `frame_done` = 0.
  - counters: `pcnt` = 0, `sel` = 0.
  - all shadows = 0.
- Because shadow `digit_en` is 0 after reset, the first frame after release is fully dark.
- Latency: `an`/`seg` reflect the `pcnt`/`sel` state of the previous cycle (one register stage).
- Frame period: `DIGITS * SCAN_DIV` clks.
- `frame_done` asserts exactly once per frame, including the first frame after reset.
- Reset asserted mid-slot: outputs go dark asynchronously. After release, scanning restarts at slot 0 with `pcnt` = 0.

## Structure
- Package `seg7_pkg`: 16-entry hex→segment constant table, `SEG_OFF` = 8'hFF, and a `clog2` helper.
- Sub-module `seg7_decode`: combinational nibble → 7-bit active-low segment decode.
- The top module holds the prescaler, slot counter, shadow registers, LZ/PWM qualification and output registers.

## Test plan
All scenarios use `DIGITS`=4, `SCAN_DIV`=16, `BRIGHT_W`=2, `BLANK_CYC`=1.

- **Reset and first frames:** release reset with `data`=16'h12A0, `digit_en`=4'hF, `brightness`=3.
  - First 64 clks: `an`=4'hF.
  - Second frame: digit0 `seg`=C0, digit1 88, digit2 A4, digit3 F9.
  - Each digit has 15 lit cycles per slot, with `an` bit low only for its own slot.
- **Minimum brightness:** `brightness`=0 → `on_len`=4; each digit is lit for exactly 3 of 16 cycles (pcnt 1..3 plus one-cycle latency).
- **Leading-zero suppression:** `blank_lz`=1.
  - `data`=16'h0050 → digits 3 and 2 dark; digit1 = 92; digit0 = C0.
  - `data`=16'h0000 → only digit0 lit, showing C0.
- **Frame coherence:** change `data` from 16'h1111 to 16'h2222 during slot 1.
  - Remainder of that frame still shows F9.
  - A4 appears only after the next `frame_done`.
  - `frame_done` pulses every 64 clks, one cycle wide.
- **DP and enable mask:** `dp`=4'b0010, `digit_en`=4'b1011.
  - Digit1 `seg[7]`=0.
  - `an[2]` stays 1 for the whole frame.
- **Async reset mid-slot:** drop `rst_n` between clock edges.
  - `an`=4'hF and `seg`=FF without a clock edge.
  - After release, the next frame is dark, then scanning resumes from digit0.
